// File: rtl/fnd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fnd_pkg : segment codes and limits shared by the FND scan blocks.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fnd_pkg;

  // Common-anode, active-low segment patterns {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'hc0;
  localparam logic [7:0] SEG_1     = 8'hf9;
  localparam logic [7:0] SEG_2     = 8'ha4;
  localparam logic [7:0] SEG_3     = 8'hb0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hf8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hff;
  localparam logic [7:0] SEG_DASH  = 8'hbf;

  localparam logic [3:0]  COM_OFF   = 4'b1111;
  localparam logic [13:0] MAX_VALUE = 14'd9999;

  typedef logic [1:0] digit_sel_t;

  function automatic logic [7:0] seg_encode(input logic [3:0] bcd);
    logic [7:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_scan_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fnd_scan_controller_if : value load bus and FND pin bundle.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface fnd_scan_controller_if;
  logic        load;
  logic [13:0] value;
  logic [3:0]  dp;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic        frame_done;

  modport master (
    output load, value, dp,
    input  fnd_com, fnd_data, frame_done
  );

  modport slave (
    input  load, value, dp,
    output fnd_com, fnd_data, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/fnd_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fnd_tick_gen : free-running divider, one-cycle tick every DIV clks.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fnd_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] tick_cnt;

  assign tick = (tick_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fnd_scan_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fnd_scan_controller : 4-digit multiplexed FND driver, frame-safe.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 250,
  parameter int LZ_BLANK = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fnd_scan_controller_if.slave bus
);

  localparam int DIV = CLK_FREQ / (SCAN_HZ * 4);

  logic        tick;
  digit_sel_t  digit_sel;
  digit_sel_t  next_sel;
  logic        boundary;
  logic [13:0] pending_val;
  logic [3:0]  pending_dp;
  logic [13:0] shadow_val;
  logic [3:0]  shadow_dp;
  logic [13:0] cur_val;
  logic [3:0]  cur_dp;
  logic [3:0]  bcd;
  logic        lead_zero;
  logic [7:0]  seg;
  logic [3:0]  com;
  logic [3:0]  fnd_com_q;
  logic [7:0]  fnd_data_q;
  logic        frame_done_q;

  fnd_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // A load on the boundary cycle bypasses the pending buffer so it makes this frame.
  always_comb begin
    boundary = tick && (digit_sel == 2'd3);
    next_sel = digit_sel + 2'd1;
    if (boundary) begin
      cur_val = bus.load ? bus.value : pending_val;
      cur_dp  = bus.load ? bus.dp    : pending_dp;
    end else begin
      cur_val = shadow_val;
      cur_dp  = shadow_dp;
    end
  end

  always_comb begin
    bcd       = 4'd0;
    lead_zero = 1'b0;
    case (next_sel)
      2'd0: begin
        bcd       = 4'(cur_val % 14'd10);
        lead_zero = 1'b0;
      end
      2'd1: begin
        bcd       = 4'((cur_val / 14'd10) % 14'd10);
        lead_zero = (cur_val < 14'd10);
      end
      2'd2: begin
        bcd       = 4'((cur_val / 14'd100) % 14'd10);
        lead_zero = (cur_val < 14'd100);
      end
      default: begin
        bcd       = 4'((cur_val / 14'd1000) % 14'd10);
        lead_zero = (cur_val < 14'd1000);
      end
    endcase
  end

  always_comb begin
    if (cur_val > MAX_VALUE) begin
      seg = SEG_DASH;
    end else if ((LZ_BLANK != 0) && lead_zero) begin
      seg = SEG_BLANK;
    end else begin
      seg = seg_encode(bcd);
    end
    if (cur_dp[next_sel]) begin
      seg[7] = 1'b0;
    end
    com           = COM_OFF;
    com[next_sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel    <= 2'd3;
      pending_val  <= '0;
      pending_dp   <= '0;
      shadow_val   <= '0;
      shadow_dp    <= '0;
      fnd_com_q    <= COM_OFF;
      fnd_data_q   <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= boundary;
      if (bus.load) begin
        pending_val <= bus.value;
        pending_dp  <= bus.dp;
      end
      if (tick) begin
        digit_sel  <= next_sel;
        fnd_com_q  <= com;
        fnd_data_q <= seg;
      end
      if (boundary) begin
        shadow_val <= cur_val;
        shadow_dp  <= cur_dp;
      end
    end
  end

  assign bus.fnd_com    = fnd_com_q;
  assign bus.fnd_data   = fnd_data_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fnd_scan_controller : directed checks of scan, blanking, loads. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fnd_scan_controller;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   edge_no;

  fnd_scan_controller_if bus();

  fnd_scan_controller #(
    .CLK_FREQ (400),
    .SCAN_HZ  (1),
    .LZ_BLANK (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic slot(input string tag, input logic [3:0] com, input logic [7:0] data);
    check({tag, "_com"},  {28'd0, bus.fnd_com},  {28'd0, com});
    check({tag, "_data"}, {24'd0, bus.fnd_data}, {24'd0, data});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic goto(input int n);
    while (edge_no < n) step();
  endtask

  task automatic set_load(input logic [13:0] v, input logic [3:0] d);
    bus.load  = 1'b1;
    bus.value = v;
    bus.dp    = d;
    step();
    bus.load  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    slot("rst_async", 4'b1111, 8'hff);
    check("rst_async_fd", {31'd0, bus.frame_done}, 32'd0);
    repeat (n) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    edge_no = 0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    edge_no   = 0;
    rst_n     = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    bus.dp    = '0;
    #3;
    do_reset(5);

    // 1234 in frame 0 (edges 100..499)
    set_load(14'd1234, 4'b0000);
    goto(99);   slot("pre_tick", 4'b1111, 8'hff);
    goto(100);  slot("f0_d0", 4'b1110, 8'h99);
    check("f0_fd_hi", {31'd0, bus.frame_done}, 32'd1);
    goto(101);  check("f0_fd_lo", {31'd0, bus.frame_done}, 32'd0);
    goto(200);  slot("f0_d1", 4'b1101, 8'hb0);
    goto(300);  slot("f0_d2", 4'b1011, 8'ha4);
    goto(400);  slot("f0_d3", 4'b0111, 8'hf9);
    goto(449);  set_load(14'd7, 4'b0000);
    goto(499);  slot("f0_hold", 4'b0111, 8'hf9);
    check("f0_fd_pre", {31'd0, bus.frame_done}, 32'd0);

    // value 7 with leading-zero blanking
    goto(500);  slot("f1_d0", 4'b1110, 8'hf8);
    check("f1_fd_hi", {31'd0, bus.frame_done}, 32'd1);
    goto(501);  check("f1_fd_lo", {31'd0, bus.frame_done}, 32'd0);
    goto(600);  slot("f1_d1", 4'b1101, 8'hff);
    goto(700);  slot("f1_d2", 4'b1011, 8'hff);
    goto(800);  slot("f1_d3", 4'b0111, 8'hff);

    // decimal point on a blanked digit
    goto(849);  set_load(14'd7, 4'b0100);
    goto(900);  slot("f2_d0", 4'b1110, 8'hf8);
    goto(1000); slot("f2_d1", 4'b1101, 8'hff);
    goto(1100); slot("f2_d2", 4'b1011, 8'h7f);
    goto(1200); slot("f2_d3", 4'b0111, 8'hff);

    // overflow shows dashes
    goto(1249); set_load(14'd12000, 4'b0000);
    goto(1300); slot("f3_d0", 4'b1110, 8'hbf);
    goto(1400); slot("f3_d1", 4'b1101, 8'hbf);
    goto(1500); slot("f3_d2", 4'b1011, 8'hbf);
    goto(1600); slot("f3_d3", 4'b0111, 8'hbf);

    // zero shows "   0"
    goto(1649); set_load(14'd0, 4'b0000);
    goto(1700); slot("f4_d0", 4'b1110, 8'hc0);
    goto(1800); slot("f4_d1", 4'b1101, 8'hff);
    goto(1900); slot("f4_d2", 4'b1011, 8'hff);
    goto(2000); slot("f4_d3", 4'b0111, 8'hff);

    // mid-frame load must not tear the current frame
    goto(2100); slot("f5_d0", 4'b1110, 8'hc0);
    goto(2249); set_load(14'd5678, 4'b0000);
    goto(2300); slot("f5_d2", 4'b1011, 8'hff);
    goto(2400); slot("f5_d3", 4'b0111, 8'hff);
    goto(2500); slot("f6_d0", 4'b1110, 8'h80);
    goto(2600); slot("f6_d1", 4'b1101, 8'hf8);
    goto(2700); slot("f6_d2", 4'b1011, 8'h82);
    goto(2800); slot("f6_d3", 4'b0111, 8'h92);

    // load on the boundary tick wins over the earlier pending value
    goto(2849); set_load(14'd9, 4'b0000);
    goto(2899); set_load(14'd42, 4'b0000);
    slot("f7_d0", 4'b1110, 8'ha4);
    check("f7_fd_hi", {31'd0, bus.frame_done}, 32'd1);
    goto(3000); slot("f7_d1", 4'b1101, 8'h99);
    goto(3100); slot("f7_d2", 4'b1011, 8'hff);

    // reset mid-frame discards the pending load
    goto(3119); set_load(14'd1111, 4'b0000);
    goto(3150);
    do_reset(3);
    goto(99);   slot("pr_pre_tick", 4'b1111, 8'hff);
    goto(100);  slot("pr_d0", 4'b1110, 8'hc0);
    check("pr_fd_hi", {31'd0, bus.frame_done}, 32'd1);
    goto(200);  slot("pr_d1", 4'b1101, 8'hff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
